// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the FP multiplier arbiter slice.
package fp_mult_pkg;

    typedef logic [31:0] fp32_t;
    typedef logic [7:0]  status_t;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RPI = 3'd2,
        RNI = 3'd3,
        RMM = 3'd4
    } rnd_mode_e;

    localparam fp32_t FP_ONE = 32'h3F80_0000;
    localparam fp32_t FP_TWO = 32'h4000_0000;

    typedef struct packed {
        fp32_t   z;
        status_t status;
        logic    id;
    } res_entry_t;

endpackage

// File: rtl/fp_res_fifo.sv
// Synchronous result FIFO with occupancy count; head is zero while empty.
module fp_res_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign count_o = count_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage carries no reset so it can map onto a register file.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_i) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Round-robin, credit-gated sharing of one fixed-latency FP multiplier
// between two requesters, with tagged results buffered in a FIFO.
module fp_mult_arbiter
    import fp_mult_pkg::*;
#(
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       req_vld_i,
    output logic [1:0]       req_rdy_o,
    input  logic [1:0][31:0] req_a_i,
    input  logic [1:0][31:0] req_b_i,
    input  logic [1:0][2:0]  req_rnd_i,
    output logic             mult_vld_in_o,
    output logic [31:0]      mult_a_o,
    output logic [31:0]      mult_b_o,
    output logic [2:0]       mult_rnd_o,
    input  logic             mult_vld_out_i,
    input  logic [31:0]      mult_z_i,
    input  logic [7:0]       mult_status_i,
    output logic             res_vld_o,
    input  logic             res_rdy_i,
    output logic [31:0]      res_z_o,
    output logic [7:0]       res_status_o,
    output logic             res_id_o,
    output logic             err_unexp_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = 4;

    logic [1:0]         gnt;
    logic               issue, gnt_id, credit;
    logic               rr_q;
    logic               mult_vld_q, mult_id_q;
    fp32_t              mult_a_q, mult_b_q;
    logic [2:0]         mult_rnd_q;
    logic [LATENCY-1:0] tag_q, tag_d;
    logic [CW-1:0]      inflight_q, inflight_d, fifo_cnt;
    logic [BW-1:0]      blank_q;
    logic               err_q;
    logic               ret_live, ret_ok, fifo_empty, pop;
    res_entry_t         push_ent, head;

    // Results already owed to the FIFO count against its free space.
    assign credit = ({1'b0, inflight_q} + {1'b0, fifo_cnt}) < (CW+1)'(FIFO_DEPTH);

    always_comb begin
        gnt = '0;
        if (credit) begin
            case (req_vld_i)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = rr_q ? 2'b10 : 2'b01;
                default: gnt = '0;
            endcase
        end
    end

    assign req_rdy_o = gnt;
    assign issue     = |gnt;
    assign gnt_id    = gnt[1];

    assign ret_live   = mult_vld_out_i && (blank_q == '0);
    assign ret_ok     = ret_live && (inflight_q != '0);
    assign inflight_d = inflight_q + CW'(issue) - CW'(ret_ok);

    // Tag shifter mirrors the multiplier pipe; the oldest slot lines up with mult_vld_out.
    always_comb begin
        tag_d    = tag_q << 1;
        tag_d[0] = mult_id_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= 1'b0;
            mult_vld_q <= 1'b0;
            mult_a_q   <= '0;
            mult_b_q   <= '0;
            mult_rnd_q <= '0;
            mult_id_q  <= 1'b0;
            tag_q      <= '0;
            inflight_q <= '0;
            blank_q    <= BW'(LATENCY);
            err_q      <= 1'b0;
        end else begin
            mult_vld_q <= issue;
            if (issue) begin
                mult_a_q   <= req_a_i[gnt_id];
                mult_b_q   <= req_b_i[gnt_id];
                mult_rnd_q <= req_rnd_i[gnt_id];
                mult_id_q  <= gnt_id;
                rr_q       <= ~gnt_id;
            end
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            if (blank_q != '0) blank_q <= blank_q - BW'(1);
            if (ret_live && (inflight_q == '0)) err_q <= 1'b1;
        end
    end

    assign push_ent = '{z: mult_z_i, status: mult_status_i, id: tag_q[LATENCY-1]};
    assign pop      = res_rdy_i && !fifo_empty;

    fp_res_fifo #(
        .WIDTH ($bits(res_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (ret_ok),
        .din_i   (push_ent),
        .pop_i   (pop),
        .dout_o  (head),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign mult_vld_in_o = mult_vld_q;
    assign mult_a_o      = mult_a_q;
    assign mult_b_o      = mult_b_q;
    assign mult_rnd_o    = mult_rnd_q;
    assign res_vld_o     = !fifo_empty;
    assign res_z_o       = head.z;
    assign res_status_o  = head.status;
    assign res_id_o      = head.id;
    assign err_unexp_o   = err_q;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Bench for fp_mult_arbiter: stub multiplier, queue-based reference model, scenario tasks.
module tb_fp_mult_arbiter;
    import fp_mult_pkg::*;

    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       req_vld, req_rdy;
    logic [1:0][31:0] req_a, req_b;
    logic [1:0][2:0]  req_rnd;
    logic             mult_vld_in, mult_vld_out;
    logic [31:0]      mult_a, mult_b, mult_z;
    logic [2:0]       mult_rnd;
    logic [7:0]       mult_status;
    logic             res_vld, res_rdy, res_id, err_unexp;
    logic [31:0]      res_z;
    logic [7:0]       res_status;
    logic             inj;

    fp_mult_arbiter #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_vld_i(req_vld), .req_rdy_o(req_rdy),
        .req_a_i(req_a), .req_b_i(req_b), .req_rnd_i(req_rnd),
        .mult_vld_in_o(mult_vld_in), .mult_a_o(mult_a), .mult_b_o(mult_b), .mult_rnd_o(mult_rnd),
        .mult_vld_out_i(mult_vld_out), .mult_z_i(mult_z), .mult_status_i(mult_status),
        .res_vld_o(res_vld), .res_rdy_i(res_rdy),
        .res_z_o(res_z), .res_status_o(res_status), .res_id_o(res_id),
        .err_unexp_o(err_unexp)
    );

    // Stub multiplier: adding biased bit patterns is exact for power-of-two scaling.
    function automatic logic [31:0] stub_z(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mag;
        mag = (a & 32'h7FFF_FFFF) + (b & 32'h7FFF_FFFF) - FP_ONE;
        return {a[31] ^ b[31], mag[30:0]};
    endfunction

    function automatic logic [7:0] stub_s(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] rnd);
        return {a[4:0] ^ b[4:0], rnd};
    endfunction

    logic [LAT-1:0] sp_v = '0;
    logic [31:0]    sp_z [LAT];
    logic [7:0]     sp_s [LAT];

    always @(posedge clk) begin
        sp_v    <= {sp_v[LAT-2:0], mult_vld_in};
        sp_z[0] <= stub_z(mult_a, mult_b);
        sp_s[0] <= stub_s(mult_a, mult_b, mult_rnd);
        for (int i = 1; i < LAT; i++) begin
            sp_z[i] <= sp_z[i-1];
            sp_s[i] <= sp_s[i-1];
        end
    end

    assign mult_vld_out = sp_v[LAT-1] | inj;
    assign mult_z       = inj ? 32'hDEAD_BEEF : sp_z[LAT-1];
    assign mult_status  = inj ? 8'hA5 : sp_s[LAT-1];

    // Reference model: accepted-but-unpopped results own credit; queue holds expected order.
    logic [40:0] q [$];
    int          m_out;
    logic        m_last;
    int          errors = 0, checks = 0;
    bit          pop_hit;
    logic [40:0] pop_act, pop_exp;

    function automatic logic [1:0] m_rdy(input logic [1:0] v);
        if (m_out >= DEPTH) return 2'b00;
        if (v == 2'b11) return m_last ? 2'b01 : 2'b10;
        return v;
    endfunction

    task automatic step();
        logic [1:0] g;
        logic       id;
        g       = m_rdy(req_vld);
        pop_hit = 1'b0;
        if (!rst && res_vld && res_rdy) begin
            pop_hit = 1'b1;
            pop_act = {res_z, res_status, res_id};
            pop_exp = (q.size() > 0) ? q.pop_front() : 'x;
            m_out--;
        end
        if (!rst && g != 2'b00) begin
            id = g[1];
            q.push_back({stub_z(req_a[id], req_b[id]), stub_s(req_a[id], req_b[id], req_rnd[id]), id});
            m_out++;
            m_last = id;
        end
        if (rst) begin
            q.delete();
            m_out  = 0;
            m_last = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_ops();
        for (int r = 0; r < 2; r++) begin
            req_a[r]   = $urandom;
            req_b[r]   = $urandom;
            req_rnd[r] = 3'($urandom_range(0, 4));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_vld = 2'b00; inj = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_vld = 2'b00; res_rdy = 1'b0; inj = 1'b0;
        rand_ops();
        step(); step();
        checks++; if (req_rdy !== 2'b00) begin errors++; $display("FAIL reset_req_rdy got=%b exp=00", req_rdy); end
        checks++; if (mult_vld_in !== 1'b0) begin errors++; $display("FAIL reset_mult_vld got=%b exp=0", mult_vld_in); end
        checks++; if (res_vld !== 1'b0) begin errors++; $display("FAIL reset_res_vld got=%b exp=0", res_vld); end
        checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_unexp); end
        checks++; if ({mult_a, mult_b, mult_rnd} !== '0) begin errors++; $display("FAIL reset_mult_ops got=%h/%h/%h exp=0", mult_a, mult_b, mult_rnd); end
        checks++; if ({res_z, res_status, res_id} !== '0) begin errors++; $display("FAIL reset_res got=%h/%h/%b exp=0", res_z, res_status, res_id); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        res_rdy = 1'b0;
        req_a[0] = 32'h3FC0_0000; req_b[0] = FP_TWO; req_rnd[0] = RNE;
        req_vld = 2'b01; #1;
        checks++; if (req_rdy !== 2'b01) begin errors++; $display("FAIL single_rdy got=%b exp=01", req_rdy); end
        step();
        req_vld = 2'b00; #1;
        checks++; if (mult_vld_in !== 1'b1 || mult_a !== 32'h3FC0_0000 || mult_b !== FP_TWO)
            begin errors++; $display("FAIL single_issue got=%b %h %h exp=1 3fc00000 40000000", mult_vld_in, mult_a, mult_b); end
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++; if (res_vld !== (k == 4)) begin errors++; $display("FAIL single_latency cyc=%0d got=%b exp=%b", k + 1, res_vld, k == 4); end
        end
        checks++; if (res_z !== 32'h4040_0000 || res_id !== 1'b0)
            begin errors++; $display("FAIL single_result got=%h id=%b exp=40400000 id=0", res_z, res_id); end
        res_rdy = 1'b1;
        step();
        checks++; if (!pop_hit || pop_act !== pop_exp) begin errors++; $display("FAIL single_pop got=%h exp=%h", pop_act, pop_exp); end
        res_rdy = 1'b0;
        checks++; if (res_vld !== 1'b0) begin errors++; $display("FAIL single_empty got=%b exp=0", res_vld); end
    endtask

    task automatic test_alternate();
        logic [1:0] seq [4];
        seq = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        res_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_ops(); req_vld = 2'b11; #1;
            checks++; if (req_rdy !== seq[i]) begin errors++; $display("FAIL alt_grant i=%0d got=%b exp=%b", i, req_rdy, seq[i]); end
            step();
        end
        req_vld = 2'b00;
        for (int i = 0; i < 12; i++) begin
            step();
            if (pop_hit) begin
                checks++; if (pop_act !== pop_exp) begin errors++; $display("FAIL alt_pop got=%h exp=%h", pop_act, pop_exp); end
            end
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL alt_drain left=%0d exp=0", q.size()); end
    endtask

    task automatic test_credit();
        int acc;
        do_reset();
        res_rdy = 1'b0; req_vld = 2'b01; acc = 0;
        for (int i = 0; i < 10; i++) begin
            rand_ops(); #1;
            checks++; if (req_rdy !== m_rdy(req_vld)) begin errors++; $display("FAIL credit_rdy i=%0d got=%b exp=%b", i, req_rdy, m_rdy(req_vld)); end
            if (req_rdy[0]) acc++;
            step();
        end
        checks++; if (acc != 4) begin errors++; $display("FAIL credit_accepts got=%0d exp=4", acc); end
        res_rdy = 1'b1; #1;
        checks++; if (req_rdy !== 2'b00) begin errors++; $display("FAIL credit_full_rdy got=%b exp=00", req_rdy); end
        step();
        checks++; if (!pop_hit || pop_act !== pop_exp) begin errors++; $display("FAIL credit_pop got=%h exp=%h", pop_act, pop_exp); end
        res_rdy = 1'b0; acc = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (req_rdy[0]) acc++;
            step();
        end
        checks++; if (acc != 1) begin errors++; $display("FAIL credit_refill got=%0d exp=1", acc); end
        req_vld = 2'b00; res_rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (pop_hit) begin
                checks++; if (pop_act !== pop_exp) begin errors++; $display("FAIL credit_drain_pop got=%h exp=%h", pop_act, pop_exp); end
            end
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL credit_drain left=%0d exp=0", q.size()); end
    endtask

    task automatic test_back_to_back();
        int npop, nacc;
        do_reset();
        npop = 0; nacc = 0;
        for (int i = 0; i < 60; i++) begin
            rand_ops();
            req_vld = (i < 20) ? 2'b01 : 2'($urandom_range(0, 3));
            res_rdy = (i < 20) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            checks++; if (req_rdy !== m_rdy(req_vld)) begin errors++; $display("FAIL b2b_rdy i=%0d got=%b exp=%b", i, req_rdy, m_rdy(req_vld)); end
            if (i < 4) begin
                checks++; if (req_rdy !== 2'b01) begin errors++; $display("FAIL b2b_burst i=%0d got=%b exp=01", i, req_rdy); end
            end
            if (req_rdy != 2'b00) nacc++;
            step();
            if (pop_hit) begin
                npop++;
                checks++; if (pop_act !== pop_exp) begin errors++; $display("FAIL b2b_pop got=%h exp=%h", pop_act, pop_exp); end
            end
        end
        req_vld = 2'b00; res_rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (pop_hit) begin
                npop++;
                checks++; if (pop_act !== pop_exp) begin errors++; $display("FAIL b2b_drain_pop got=%h exp=%h", pop_act, pop_exp); end
            end
        end
        checks++; if (npop != nacc || q.size() != 0) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", npop, nacc); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        res_rdy = 1'b0; req_vld = 2'b01;
        for (int i = 0; i < 3; i++) begin rand_ops(); step(); end
        req_vld = 2'b00;
        step(); step();
        checks++; if (res_vld !== 1'b1) begin errors++; $display("FAIL mid_pre_fill got=%b exp=1", res_vld); end
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if ({res_vld, mult_vld_in, req_rdy, err_unexp} !== 5'b0 || {res_z, res_status, res_id} !== '0)
            begin errors++; $display("FAIL mid_reset_outs got=%b%b%b%b z=%h exp=0", res_vld, mult_vld_in, req_rdy, err_unexp, res_z); end
        step();
        inj = 1'b1; step(); inj = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (err_unexp !== 1'b0 || res_vld !== 1'b0)
                begin errors++; $display("FAIL mid_blank i=%0d got err=%b vld=%b exp=0 0", i, err_unexp, res_vld); end
        end
    endtask

    task automatic test_spurious();
        for (int i = 0; i < 3; i++) step();
        inj = 1'b1; step(); inj = 1'b0;
        checks++; if (err_unexp !== 1'b1) begin errors++; $display("FAIL spur_err got=%b exp=1", err_unexp); end
        checks++; if (res_vld !== 1'b0) begin errors++; $display("FAIL spur_fifo got=%b exp=0", res_vld); end
        for (int i = 0; i < 3; i++) step();
        checks++; if (err_unexp !== 1'b1) begin errors++; $display("FAIL spur_sticky got=%b exp=1", err_unexp); end
        do_reset();
        checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL spur_clear got=%b exp=0", err_unexp); end
    endtask

    initial begin
        rst = 1'b1; req_vld = 2'b00; res_rdy = 1'b0; inj = 1'b0;
        req_a = '0; req_b = '0; req_rnd = '0;
        m_out = 0; m_last = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_alternate();
        test_credit();
        test_back_to_back();
        test_reset_mid();
        test_spurious();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
